// File: rtl/mem_access_ctrl_pkg.sv
// Shared types and codes for the memory access controller.
// Size decoding helpers live here so top and sub-module agree.
package mem_access_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        WAIT = 2'b01,
        DONE = 2'b10
    } state_t;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    localparam logic [1:0] REG_WR_SRC_MEM = 2'b10;

    // The reserved size code behaves as a word access.
    function automatic logic [1:0] norm_size(input logic [1:0] s);
        return (s == 2'b11) ? SZ_WORD : s;
    endfunction

    function automatic logic is_aligned(input logic [1:0] s, input logic [1:0] a);
        case (s)
            SZ_BYTE: return 1'b1;
            SZ_HALF: return ~a[0];
            default: return (a == 2'b00);
        endcase
    endfunction

    function automatic logic [3:0] byte_en(input logic [1:0] s, input logic [1:0] a);
        case (s)
            SZ_BYTE: return 4'b0001 << a;
            SZ_HALF: return a[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_ctrl_if.sv
// Word-oriented memory bus between the controller and memory.
// The controller drives the request side, memory answers with ack/rdata.
interface mem_access_ctrl_if #(
    parameter int operand_width = 32
);
    logic                     bus_req;
    logic                     bus_we;
    logic [operand_width-1:0] bus_addr;
    logic [3:0]               bus_be;
    logic [operand_width-1:0] bus_wdata;
    logic                     bus_ack;
    logic [operand_width-1:0] bus_rdata;

    modport master (
        output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
        input  bus_ack, bus_rdata
    );

    modport slave (
        input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
        output bus_ack, bus_rdata
    );
endinterface

// File: rtl/mem_access_ctrl_load_extend.sv
// Picks the addressed lane out of a read word and sign/zero-extends it.
// Purely combinational; the caller registers the result.
module load_extend
    import mem_access_ctrl_pkg::*;
#(
    parameter int operand_width = 32
) (
    input  logic [operand_width-1:0] rdata,
    input  logic [1:0]               addr_lo,
    input  logic [1:0]               size,
    input  logic                     is_unsigned,
    output logic [operand_width-1:0] data
);
    logic [operand_width-1:0] lane;

    // Shift the addressed lane down to bit 0, then extend to full width.
    always_comb begin
        lane = rdata >> {addr_lo, 3'b000};
        case (size)
            SZ_BYTE: data = {{(operand_width-8){~is_unsigned & lane[7]}}, lane[7:0]};
            SZ_HALF: data = {{(operand_width-16){~is_unsigned & lane[15]}}, lane[15:0]};
            default: data = lane;
        endcase
    end
endmodule

// File: rtl/mem_access_ctrl.sv
// Load/store unit between EXMEM and a word bus; stalls the pipeline
// while a bus transaction is outstanding, with alignment and timeout checks.
module mem_access_ctrl
    import mem_access_ctrl_pkg::*;
#(
    parameter int operand_width  = 32,
    parameter int timeout_cycles = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     mem_read_in,
    input  logic                     mem_write_in,
    input  logic [1:0]               mem_size_in,
    input  logic                     mem_unsigned_in,
    input  logic [operand_width-1:0] addr_in,
    input  logic [operand_width-1:0] store_data_in,
    mem_access_ctrl_if.master        bus,
    output logic                     stall_out,
    output logic [operand_width-1:0] load_data_out,
    output logic                     misalign_out,
    output logic                     timeout_out
);
    localparam int CW = $clog2(timeout_cycles + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(timeout_cycles - 1);

    state_t                   state;
    logic [CW-1:0]            cnt;
    logic                     pend_load;
    logic                     pend_uns;
    logic [1:0]               pend_size;
    logic [1:0]               pend_lo;
    logic [1:0]               size;
    logic                     access;
    logic                     ok;
    logic [operand_width-1:0] wmask;
    logic [operand_width-1:0] wdata_sh;
    logic [operand_width-1:0] ext;

    // Decode the incoming request and place store data on its byte lanes.
    always_comb begin
        size   = norm_size(mem_size_in);
        access = mem_read_in | mem_write_in;
        ok     = is_aligned(size, addr_in[1:0]);
        case (size)
            SZ_BYTE: wmask = {{(operand_width-8){1'b0}}, store_data_in[7:0]};
            SZ_HALF: wmask = {{(operand_width-16){1'b0}}, store_data_in[15:0]};
            default: wmask = store_data_in;
        endcase
        wdata_sh = wmask << {addr_in[1:0], 3'b000};
    end

    assign stall_out = (state == WAIT) || (state == IDLE && access && ok);

    load_extend #(.operand_width(operand_width)) u_ext (
        .rdata       (bus.bus_rdata),
        .addr_lo     (pend_lo),
        .size        (pend_size),
        .is_unsigned (pend_uns),
        .data        (ext)
    );

    // Transaction FSM: accept in IDLE, hold the bus in WAIT, release in DONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            cnt           <= '0;
            bus.bus_req   <= 1'b0;
            bus.bus_we    <= 1'b0;
            bus.bus_be    <= 4'b0000;
            bus.bus_addr  <= '0;
            bus.bus_wdata <= '0;
            load_data_out <= '0;
            misalign_out  <= 1'b0;
            timeout_out   <= 1'b0;
            pend_load     <= 1'b0;
            pend_uns      <= 1'b0;
            pend_size     <= SZ_WORD;
            pend_lo       <= 2'b00;
        end else begin
            misalign_out <= 1'b0;
            timeout_out  <= 1'b0;
            case (state)
                IDLE: begin
                    if (access && !ok) begin
                        misalign_out <= 1'b1;
                    end else if (access) begin
                        bus.bus_req   <= 1'b1;
                        bus.bus_we    <= mem_write_in;
                        bus.bus_be    <= byte_en(size, addr_in[1:0]);
                        bus.bus_addr  <= {addr_in[operand_width-1:2], 2'b00};
                        bus.bus_wdata <= wdata_sh;
                        pend_load     <= ~mem_write_in;
                        pend_uns      <= mem_unsigned_in;
                        pend_size     <= size;
                        pend_lo       <= addr_in[1:0];
                        cnt           <= '0;
                        state         <= WAIT;
                    end
                end
                WAIT: begin
                    if (bus.bus_ack) begin
                        if (pend_load) load_data_out <= ext;
                        bus.bus_req <= 1'b0;
                        bus.bus_we  <= 1'b0;
                        state       <= DONE;
                    end else if (cnt == CNT_MAX) begin
                        bus.bus_req   <= 1'b0;
                        bus.bus_we    <= 1'b0;
                        timeout_out   <= 1'b1;
                        load_data_out <= '0;
                        state         <= DONE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: loads, stores, alignment,
// timeout and reset behaviour against hand-computed values.
module tb_mem_access_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic        mem_read_in;
    logic        mem_write_in;
    logic [1:0]  mem_size_in;
    logic        mem_unsigned_in;
    logic [31:0] addr_in;
    logic [31:0] store_data_in;
    logic        stall_out;
    logic [31:0] load_data_out;
    logic        misalign_out;
    logic        timeout_out;
    int          passed = 0;
    int          total  = 0;

    mem_access_ctrl_if #(.operand_width(32)) bif ();

    mem_access_ctrl #(.operand_width(32), .timeout_cycles(16)) dut (
        .clk             (clk),
        .rst             (rst),
        .mem_read_in     (mem_read_in),
        .mem_write_in    (mem_write_in),
        .mem_size_in     (mem_size_in),
        .mem_unsigned_in (mem_unsigned_in),
        .addr_in         (addr_in),
        .store_data_in   (store_data_in),
        .bus             (bif),
        .stall_out       (stall_out),
        .load_data_out   (load_data_out),
        .misalign_out    (misalign_out),
        .timeout_out     (timeout_out)
    );

    always #5 clk = ~clk;

    // Start a request at the current negedge and ack it lag cycles after bus_req.
    task automatic run_access(input logic rd, input logic wr, input logic [1:0] sz,
                              input logic uns, input logic [31:0] a,
                              input logic [31:0] wd, input logic [31:0] rdv,
                              input int lag);
        mem_read_in = rd; mem_write_in = wr; mem_size_in = sz;
        mem_unsigned_in = uns; addr_in = a; store_data_in = wd;
        @(negedge clk);
        repeat (lag) @(negedge clk);
        bif.bus_ack = 1'b1; bif.bus_rdata = rdv;
        @(negedge clk);
        bif.bus_ack = 1'b0;
        mem_read_in = 1'b0; mem_write_in = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        mem_read_in = 0; mem_write_in = 0; mem_size_in = 2'b10;
        mem_unsigned_in = 0; addr_in = '0; store_data_in = '0;
        bif.bus_ack = 0; bif.bus_rdata = '0;
        @(negedge clk);
        total++; if (bif.bus_req !== 1'b0) $display("FAIL rst_req got=%b exp=0", bif.bus_req); else passed++;
        total++; if (bif.bus_be !== 4'b0000) $display("FAIL rst_be got=%b exp=0000", bif.bus_be); else passed++;
        total++; if (stall_out !== 1'b0) $display("FAIL rst_stall got=%b exp=0", stall_out); else passed++;
        total++; if (load_data_out !== 32'h0) $display("FAIL rst_load got=%h exp=0", load_data_out); else passed++;
        total++; if ({misalign_out, timeout_out} !== 2'b00) $display("FAIL rst_err got=%b exp=00", {misalign_out, timeout_out}); else passed++;
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_lw();
        mem_read_in = 1; mem_size_in = 2'b10; mem_unsigned_in = 0; addr_in = 32'h100;
        #1;
        total++; if (stall_out !== 1'b1) $display("FAIL lw_stall_c0 got=%b exp=1", stall_out); else passed++;
        total++; if (bif.bus_req !== 1'b0) $display("FAIL lw_req_c0 got=%b exp=0", bif.bus_req); else passed++;
        @(negedge clk);
        total++; if (bif.bus_req !== 1'b1) $display("FAIL lw_req_c1 got=%b exp=1", bif.bus_req); else passed++;
        total++; if (bif.bus_addr !== 32'h100) $display("FAIL lw_addr got=%h exp=100", bif.bus_addr); else passed++;
        total++; if (bif.bus_be !== 4'b1111) $display("FAIL lw_be got=%b exp=1111", bif.bus_be); else passed++;
        total++; if (bif.bus_we !== 1'b0) $display("FAIL lw_we got=%b exp=0", bif.bus_we); else passed++;
        total++; if (stall_out !== 1'b1) $display("FAIL lw_stall_c1 got=%b exp=1", stall_out); else passed++;
        @(negedge clk);
        total++; if (stall_out !== 1'b1) $display("FAIL lw_stall_c2 got=%b exp=1", stall_out); else passed++;
        bif.bus_ack = 1; bif.bus_rdata = 32'hDEADBEEF;
        #1;
        total++; if (stall_out !== 1'b1) $display("FAIL lw_stall_c3 got=%b exp=1", stall_out); else passed++;
        @(negedge clk);
        bif.bus_ack = 0;
        total++; if (stall_out !== 1'b0) $display("FAIL lw_stall_done got=%b exp=0", stall_out); else passed++;
        total++; if (bif.bus_req !== 1'b0) $display("FAIL lw_req_done got=%b exp=0", bif.bus_req); else passed++;
        total++; if (load_data_out !== 32'hDEADBEEF) $display("FAIL lw_data got=%h exp=deadbeef", load_data_out); else passed++;
        mem_read_in = 0;
        @(negedge clk);
        total++; if (load_data_out !== 32'hDEADBEEF) $display("FAIL lw_hold got=%h exp=deadbeef", load_data_out); else passed++;
    endtask

    task automatic test_store();
        logic [31:0] va [4] = '{32'h102, 32'h101, 32'h104, 32'h103};
        logic [1:0]  vs [4] = '{2'b01, 2'b00, 2'b10, 2'b00};
        logic [31:0] vd [4] = '{32'h0000ABCD, 32'h12345677, 32'hCAFEF00D, 32'h000000A5};
        logic [3:0]  vb [4] = '{4'b1100, 4'b0010, 4'b1111, 4'b1000};
        logic [31:0] vw [4] = '{32'hABCD0000, 32'h00007700, 32'hCAFEF00D, 32'hA5000000};
        logic [31:0] vaddr [4] = '{32'h100, 32'h100, 32'h104, 32'h100};
        for (int i = 0; i < 4; i++) begin
            mem_write_in = 1; mem_read_in = (i == 3); mem_size_in = vs[i];
            addr_in = va[i]; store_data_in = vd[i];
            @(negedge clk);
            total++; if (bif.bus_be !== vb[i]) $display("FAIL st%0d_be got=%b exp=%b", i, bif.bus_be, vb[i]); else passed++;
            total++; if (bif.bus_wdata !== vw[i]) $display("FAIL st%0d_wdata got=%h exp=%h", i, bif.bus_wdata, vw[i]); else passed++;
            total++; if (bif.bus_we !== 1'b1) $display("FAIL st%0d_we got=%b exp=1", i, bif.bus_we); else passed++;
            total++; if (bif.bus_addr !== vaddr[i]) $display("FAIL st%0d_addr got=%h exp=%h", i, bif.bus_addr, vaddr[i]); else passed++;
            bif.bus_ack = 1; bif.bus_rdata = 32'h55555555;
            @(negedge clk);
            bif.bus_ack = 0; mem_write_in = 0; mem_read_in = 0;
            total++; if (stall_out !== 1'b0) $display("FAIL st%0d_done_stall got=%b exp=0", i, stall_out); else passed++;
            total++; if (load_data_out !== 32'hDEADBEEF) $display("FAIL st%0d_load_kept got=%h exp=deadbeef", i, load_data_out); else passed++;
            @(negedge clk);
        end
    endtask

    task automatic test_load_extend();
        logic [31:0] va [6] = '{32'h103, 32'h103, 32'h102, 32'h101, 32'h100, 32'h100};
        logic [1:0]  vs [6] = '{2'b00, 2'b00, 2'b01, 2'b00, 2'b01, 2'b11};
        logic        vu [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        logic [31:0] vr [6] = '{32'h80000000, 32'h80000000, 32'h80011234,
                                32'h00007F00, 32'h1234F00F, 32'h89ABCDEF};
        logic [31:0] ve [6] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF8001,
                                32'h0000007F, 32'h0000F00F, 32'h89ABCDEF};
        for (int i = 0; i < 6; i++) begin
            run_access(1'b1, 1'b0, vs[i], vu[i], va[i], 32'h0, vr[i], 1);
            total++; if (load_data_out !== ve[i]) $display("FAIL ld%0d_data got=%h exp=%h", i, load_data_out, ve[i]); else passed++;
            @(negedge clk);
        end
    endtask

    task automatic test_misalign();
        logic [31:0] va [2] = '{32'h101, 32'h103};
        logic [1:0]  vs [2] = '{2'b10, 2'b01};
        for (int i = 0; i < 2; i++) begin
            mem_read_in = 1; mem_size_in = vs[i]; addr_in = va[i];
            #1;
            total++; if (stall_out !== 1'b0) $display("FAIL mis%0d_stall got=%b exp=0", i, stall_out); else passed++;
            @(negedge clk);
            total++; if (misalign_out !== 1'b1) $display("FAIL mis%0d_pulse got=%b exp=1", i, misalign_out); else passed++;
            total++; if (bif.bus_req !== 1'b0) $display("FAIL mis%0d_req got=%b exp=0", i, bif.bus_req); else passed++;
            mem_read_in = 0;
            @(negedge clk);
            total++; if (misalign_out !== 1'b0) $display("FAIL mis%0d_end got=%b exp=0", i, misalign_out); else passed++;
            total++; if (bif.bus_req !== 1'b0) $display("FAIL mis%0d_req2 got=%b exp=0", i, bif.bus_req); else passed++;
        end
    endtask

    task automatic test_timeout();
        mem_read_in = 1; mem_size_in = 2'b10; mem_unsigned_in = 0; addr_in = 32'h200;
        repeat (16) @(negedge clk);
        total++; if (bif.bus_req !== 1'b1) $display("FAIL to_req_c16 got=%b exp=1", bif.bus_req); else passed++;
        total++; if (timeout_out !== 1'b0) $display("FAIL to_early got=%b exp=0", timeout_out); else passed++;
        total++; if (load_data_out !== 32'h89ABCDEF) $display("FAIL to_hold got=%h exp=89abcdef", load_data_out); else passed++;
        @(negedge clk);
        mem_read_in = 0;
        total++; if (timeout_out !== 1'b1) $display("FAIL to_pulse got=%b exp=1", timeout_out); else passed++;
        total++; if (bif.bus_req !== 1'b0) $display("FAIL to_req_drop got=%b exp=0", bif.bus_req); else passed++;
        total++; if (load_data_out !== 32'h0) $display("FAIL to_data got=%h exp=0", load_data_out); else passed++;
        total++; if (stall_out !== 1'b0) $display("FAIL to_stall got=%b exp=0", stall_out); else passed++;
        @(negedge clk);
        total++; if (timeout_out !== 1'b0) $display("FAIL to_end got=%b exp=0", timeout_out); else passed++;
        run_access(1'b1, 1'b0, 2'b10, 1'b0, 32'h204, 32'h0, 32'h13579BDF, 15);
        total++; if (timeout_out !== 1'b0) $display("FAIL ack16_to got=%b exp=0", timeout_out); else passed++;
        total++; if (load_data_out !== 32'h13579BDF) $display("FAIL ack16_data got=%h exp=13579bdf", load_data_out); else passed++;
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        run_access(1'b1, 1'b0, 2'b00, 1'b1, 32'h302, 32'h0, 32'h00C30000, 0);
        total++; if (load_data_out !== 32'h000000C3) $display("FAIL b2b0_data got=%h exp=000000c3", load_data_out); else passed++;
        @(negedge clk);
        run_access(1'b1, 1'b0, 2'b01, 1'b0, 32'h300, 32'h0, 32'h00007FFE, 0);
        total++; if (load_data_out !== 32'h00007FFE) $display("FAIL b2b1_data got=%h exp=00007ffe", load_data_out); else passed++;
        @(negedge clk);
    endtask

    task automatic test_reset_mid_wait();
        mem_read_in = 1; mem_size_in = 2'b10; addr_in = 32'h300;
        @(negedge clk);
        @(negedge clk);
        total++; if (bif.bus_req !== 1'b1) $display("FAIL rw_req_pre got=%b exp=1", bif.bus_req); else passed++;
        rst = 1; mem_read_in = 0;
        #1;
        total++; if (bif.bus_req !== 1'b0) $display("FAIL rw_req_now got=%b exp=0", bif.bus_req); else passed++;
        total++; if (load_data_out !== 32'h0) $display("FAIL rw_load got=%h exp=0", load_data_out); else passed++;
        @(negedge clk);
        rst = 0; bif.bus_ack = 1; bif.bus_rdata = 32'hFFFFFFFF;
        @(negedge clk);
        bif.bus_ack = 0;
        total++; if (load_data_out !== 32'h0) $display("FAIL rw_late_ack got=%h exp=0", load_data_out); else passed++;
        total++; if ({bif.bus_req, stall_out} !== 2'b00) $display("FAIL rw_idle got=%b exp=00", {bif.bus_req, stall_out}); else passed++;
        total++; if ({misalign_out, timeout_out} !== 2'b00) $display("FAIL rw_err got=%b exp=00", {misalign_out, timeout_out}); else passed++;
    endtask

    initial begin
        test_reset();
        test_lw();
        test_store();
        test_load_extend();
        test_misalign();
        test_timeout();
        test_back_to_back();
        test_reset_mid_wait();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 Parameters SHALL be: operand_width, default 32, data/address width; timeout_cycles, default 16, maximum bus wait cycles before abort.
REQ-002 Port clk, input, 1: single clock, all state on rising edge.
REQ-003 Port rst, input, 1: reset, asynchronous and active-high.
REQ-004 Port mem_read_in / mem_write_in, input, 1 each: load / store request from the EXMEM stage.
REQ-005 Port mem_size_in, input, 2: 00 byte, 01 half, 10 word; 11 is treated as word.
REQ-006 Port mem_unsigned_in, input, 1: zero-extend a load when 1, sign-extend when 0.
REQ-007 Port addr_in and store_data_in, input, operand_width each: byte address and store data.
REQ-008 Port bus_req, bus_we, output, 1 each: bus request and write enable.
REQ-009 Port bus_addr, output, operand_width: word-aligned address, addr_in with bits [1:0] forced to 00.
REQ-010 Port bus_be, output, 4: byte enables; bus_wdata, output, operand_width: lane-shifted store data.
REQ-011 Port bus_ack, input, 1: completion; bus_rdata, input, operand_width: read word, valid with bus_ack.
REQ-012 Port stall_out, output, 1: freezes all pipeline registers while high.
REQ-013 Port load_data_out, output, operand_width: extended load result, feeds memory_data_in of the MEMWB stage.
REQ-014 Port misalign_out and timeout_out, output, 1 each: one-cycle error pulses.

Function
REQ-015 The FSM SHALL have three states: IDLE, WAIT and DONE.
REQ-016 An access SHALL be (mem_read_in | mem_write_in) sampled in IDLE; when both are high, only the store SHALL be performed.
REQ-017 Aligned: byte always; half when addr_in[0]=0; word when addr_in[1:0]=00.
REQ-018 On a misaligned access in IDLE, the block SHALL pulse misalign_out for 1 cycle, issue no bus request, keep stall_out=0 and remain in IDLE.
REQ-019 On an aligned access in IDLE, stall_out SHALL be 1 combinationally in that cycle.
REQ-019a In that same case, the block SHALL register bus_req=1 and the address, byte-enables, write data and bus_we, then move to WAIT.
REQ-020 In WAIT, stall_out=1 and bus_req=1 SHALL hold, with all bus outputs stable until bus_ack.
REQ-021 bus_ack SHALL be ignored outside WAIT.
REQ-022 On bus_ack in WAIT, a load SHALL register the extracted lane into load_data_out, extended per mem_unsigned_in.
REQ-022a On the same event the block SHALL drop bus_req and move to DONE.
REQ-023 A wait counter SHALL clear on entry to WAIT and increment each WAIT cycle without bus_ack.
REQ-023a When the counter reaches timeout_cycles-1 without bus_ack, the block SHALL drop bus_req, pulse timeout_out, set load_data_out=0 and move to DONE.
REQ-024 If bus_ack arrives in the timeout cycle, the ack SHALL win and no timeout SHALL be flagged.
REQ-025 DONE SHALL last exactly 1 cycle with stall_out=0 and then move to IDLE unconditionally, so the pipeline advances once.
REQ-026 Load latency from IDLE acceptance to load_data_out valid SHALL be N+2 cycles, where N is the number of cycles bus_ack lags bus_req.
REQ-027 load_data_out SHALL hold its value until the next completed load or timeout.
REQ-028 Byte enables SHALL be: byte = 0001<<addr[1:0]; half = 0011<<(addr[1]*2); word = 1111.

Reset
REQ-029 rst SHALL immediately force state=IDLE, counter=0, bus_req=0, bus_we=0, bus_be=0, bus_addr=0, bus_wdata=0.
REQ-029a rst SHALL also immediately force load_data_out=0 and misalign_out=timeout_out=0; stall_out then evaluates from IDLE.
REQ-030 Reset during WAIT SHALL abandon the transaction with no error pulse; a late bus_ack after release SHALL be ignored.

Structure
REQ-031 A shared package SHALL hold the FSM state encoding, the mem_size codes (BYTE/HALF/WORD) and the reg_wr_src code 2'b10 (memory).
REQ-032 Load lane extraction and extension SHALL be one combinational sub-module, load_extend.

Verification
REQ-033 lw from 0x100 with bus_ack 2 cycles after bus_req, bus_rdata=0xDEADBEEF -> stall high 4 cycles, load_data_out=0xDEADBEEF, DONE stall low.
REQ-034 lb signed, addr 0x103, rdata=0x80000000 -> bus_be ignored for reads, load_data_out=0xFFFFFF80; lbu -> 0x00000080.
REQ-035 sh, addr 0x102, data 0x0000ABCD -> bus_be=1100, bus_wdata=0xABCD0000, bus_we=1.
REQ-036 lw from 0x101 -> misalign_out 1 cycle, bus_req never high, stall_out=0.
REQ-037 No bus_ack for 16 WAIT cycles -> timeout_out pulse, load_data_out=0; ack on cycle 16 -> no timeout.
REQ-038 rst asserted mid-WAIT -> bus_req low the same cycle, state IDLE, late bus_ack ignored.
